// File: rtl/neuromorphic_asic_bridge.sv
// ----------------------------------------------------------------------------
// neuromorphic_asic_bridge
//
// AXI4-Lite slave bridge between the processing system and an external
// neuromorphic ASIC. It drives 16 PWM-encoded input lines toward the ASIC and
// counts output spikes returned on 4 differential auxiliary channels.
//
// Register map (ADDR[3:2] selects the word, ADDR[8:4] must be zero):
//   0x00 CTRL   bit0 ENABLE (R/W), bit1 CLEAR (write-1 zeroes spike counters)
//   0x04 SPIKES byte i = 8-bit spike counter of channel i (read-only)
//   0x08 PWMCFG [15:0] line mask, [23:16] duty, [31:24] reserved (stored)
//   0x0C        reads 0
//
// Ports:
//   S_AXI_ACLK            system clock, also the PWM clock
//   S_AXI_ARESET          synchronous active-high reset
//   S_AXI_AW*/W*/B*       AXI4-Lite write address, data and response channels
//   S_AXI_AR*/R*          AXI4-Lite read address and data channels
//   VAUXP / VAUXN         ASIC spike outputs, positive and negative legs
//   digit                 PWM input lines to the ASIC
//
// Build option:
//   NAB_PWM_PRESCALE_EN   when defined, the PWM counter advances once every
//                         PWM_PRESCALE cycles instead of every cycle.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module neuromorphic_asic_bridge #(
    parameter int PWM_PRESCALE = 4
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESET,
    input  logic [8:0]  S_AXI_AWADDR,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [8:0]  S_AXI_ARADDR,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    input  logic [3:0]  VAUXP,
    input  logic [3:0]  VAUXN,
    output logic [15:0] digit
);

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACK,
        WR_RESP
    } wrState_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ACK,
        RD_DATA
    } rdState_t;

    wrState_t wrState_q, wrState_d;
    rdState_t rdState_q, rdState_d;

    logic        writeCommit;
    logic        readAccept;
    logic        wrMapped;
    logic [1:0]  wrWord;
    logic        clearHit;

    logic        ctrlEnable_q;
    logic [31:0] pwmCfg_q;
    logic [3:0][7:0] spikeCnt_q;
    logic [31:0] rdata_q;
    logic [31:0] readData_d;

    logic [7:0]  pwmCnt_q;
    logic        pwmTick;
    logic [15:0] digit_q;

    logic [3:0]  syncP1_q, syncP2_q;
    logic [3:0]  syncN1_q, syncN2_q;
    logic [3:0]  levelPrev_q;
    logic [3:0]  spikeLevel;
    logic [3:0]  spikeRise;

    logic        unusedSignals;

    // Byte strobes and the byte offset bits carry no meaning for this block.
    assign unusedSignals = ^{S_AXI_WSTRB, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ------------------------------------------------------------------------
    // Write channel: one transaction at a time. A write is accepted only from
    // idle with both address and data valid; READY pulses for one cycle in
    // WR_ACK, and BVALID stays up until the master takes the response.
    // ------------------------------------------------------------------------
    assign writeCommit = (wrState_q == WR_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wrState_q <= WR_IDLE;
        end else begin
            wrState_q <= wrState_d;
        end
    end

    always_comb begin
        wrState_d = wrState_q;
        case (wrState_q)
            WR_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    wrState_d = WR_ACK;
                end
            end
            WR_ACK: begin
                wrState_d = S_AXI_BREADY ? WR_IDLE : WR_RESP;
            end
            WR_RESP: begin
                if (S_AXI_BREADY) begin
                    wrState_d = WR_IDLE;
                end
            end
            default: wrState_d = WR_IDLE;
        endcase
    end

    assign S_AXI_AWREADY = (wrState_q == WR_ACK);
    assign S_AXI_WREADY  = (wrState_q == WR_ACK);
    assign S_AXI_BVALID  = (wrState_q == WR_ACK) || (wrState_q == WR_RESP);
    assign S_AXI_BRESP   = 2'b00;

    // ------------------------------------------------------------------------
    // Read channel: mirrors the write side. RDATA is captured on the accept
    // edge so it stays stable however long the master stalls RREADY.
    // ------------------------------------------------------------------------
    assign readAccept = (rdState_q == RD_IDLE) && S_AXI_ARVALID;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rdState_q <= RD_IDLE;
        end else begin
            rdState_q <= rdState_d;
        end
    end

    always_comb begin
        rdState_d = rdState_q;
        case (rdState_q)
            RD_IDLE: begin
                if (S_AXI_ARVALID) begin
                    rdState_d = RD_ACK;
                end
            end
            RD_ACK: begin
                rdState_d = S_AXI_RREADY ? RD_IDLE : RD_DATA;
            end
            RD_DATA: begin
                if (S_AXI_RREADY) begin
                    rdState_d = RD_IDLE;
                end
            end
            default: rdState_d = RD_IDLE;
        endcase
    end

    assign S_AXI_ARREADY = (rdState_q == RD_ACK);
    assign S_AXI_RVALID  = (rdState_q == RD_ACK) || (rdState_q == RD_DATA);
    assign S_AXI_RRESP   = 2'b00;

    // Read decode; anything with ADDR[8:4] set is unmapped and returns zero.
    always_comb begin
        readData_d = 32'h0;
        if (S_AXI_ARADDR[8:4] == 5'd0) begin
            case (S_AXI_ARADDR[3:2])
                2'd0:    readData_d = {31'h0, ctrlEnable_q};
                2'd1:    readData_d = spikeCnt_q;
                2'd2:    readData_d = pwmCfg_q;
                default: readData_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rdata_q <= 32'h0;
        end else if (readAccept) begin
            rdata_q <= readData_d;
        end
    end

    assign S_AXI_RDATA = rdata_q;

    // ------------------------------------------------------------------------
    // Register file. Writes land on the accept edge; CLEAR is a self-clearing
    // strobe that only acts on that same edge.
    // ------------------------------------------------------------------------
    assign wrMapped = (S_AXI_AWADDR[8:4] == 5'd0);
    assign wrWord   = S_AXI_AWADDR[3:2];
    assign clearHit = writeCommit && wrMapped && (wrWord == 2'd0) && S_AXI_WDATA[1];

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            ctrlEnable_q <= 1'b0;
            pwmCfg_q     <= 32'h0;
        end else if (writeCommit && wrMapped) begin
            if (wrWord == 2'd0) begin
                ctrlEnable_q <= S_AXI_WDATA[0];
            end
            if (wrWord == 2'd2) begin
                pwmCfg_q <= S_AXI_WDATA;
            end
        end
    end

    // ------------------------------------------------------------------------
    // PWM advance strobe. With the prescaler built in, the divider restarts
    // whenever the block is disabled so every enable starts a fresh period.
    // ------------------------------------------------------------------------
`ifdef NAB_PWM_PRESCALE_EN
    localparam int PRESC_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

    logic [PRESC_W-1:0] prescCnt_q;

    assign pwmTick = (prescCnt_q == PRESC_W'(PWM_PRESCALE - 1));

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET || !ctrlEnable_q) begin
            prescCnt_q <= '0;
        end else if (pwmTick) begin
            prescCnt_q <= '0;
        end else begin
            prescCnt_q <= prescCnt_q + 1'b1;
        end
    end
`else
    localparam int unusedPrescale = PWM_PRESCALE;

    assign pwmTick = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // PWM counter and registered line outputs. The counter is parked at zero
    // while disabled; the 8-bit width gives the 256-step wrap for free.
    // ------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET || !ctrlEnable_q) begin
            pwmCnt_q <= 8'h0;
        end else if (pwmTick) begin
            pwmCnt_q <= pwmCnt_q + 8'd1;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            digit_q <= 16'h0;
        end else if (ctrlEnable_q && (pwmCnt_q < pwmCfg_q[23:16])) begin
            digit_q <= pwmCfg_q[15:0];
        end else begin
            digit_q <= 16'h0;
        end
    end

    assign digit = digit_q;

    // ------------------------------------------------------------------------
    // Spike inputs come from the ASIC asynchronously, so both legs go through
    // two flops before the differential level is formed.
    // ------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            syncP1_q    <= 4'h0;
            syncP2_q    <= 4'h0;
            syncN1_q    <= 4'h0;
            syncN2_q    <= 4'h0;
            levelPrev_q <= 4'h0;
        end else begin
            syncP1_q    <= VAUXP;
            syncP2_q    <= syncP1_q;
            syncN1_q    <= VAUXN;
            syncN2_q    <= syncN1_q;
            levelPrev_q <= spikeLevel;
        end
    end

    assign spikeLevel = syncP2_q & ~syncN2_q;
    assign spikeRise  = spikeLevel & ~levelPrev_q;

    // ------------------------------------------------------------------------
    // Spike counters. CLEAR wins over an increment landing on the same edge;
    // the edge detector keeps tracking while disabled so re-enabling with a
    // line already high does not produce a phantom count.
    // ------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET || clearHit) begin
            spikeCnt_q <= '0;
        end else if (ctrlEnable_q) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (spikeRise[ch]) begin
                    spikeCnt_q[ch] <= spikeCnt_q[ch] + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_neuromorphic_asic_bridge.sv
// ----------------------------------------------------------------------------
// tb_neuromorphic_asic_bridge
//
// Self-checking bench for neuromorphic_asic_bridge. A behavioural model keeps
// the register contents, per-channel spike totals (counted from the levels
// the bench drives) and the cycle on which ENABLE last turned on, from which
// the expected PWM phase of every cycle is worked out.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_neuromorphic_asic_bridge;

    logic        S_AXI_ACLK = 1'b0;
    logic        S_AXI_ARESET = 1'b1;
    logic [8:0]  S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [8:0]  S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [3:0]  VAUXP = '0;
    logic [3:0]  VAUXN = '0;
    logic [15:0] digit;

    int checkCount = 0;
    int passCount = 0;
    int cycleNum = 0;

    // Behavioural model state
    bit          modelEnable = 1'b0;
    logic [31:0] modelPwmCfg = '0;
    int          modelCount [4] = '{0, 0, 0, 0};
    logic [3:0]  drvLevel = '0;
    int          enableEdge = 0;

    neuromorphic_asic_bridge dut (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESET (S_AXI_ARESET),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .VAUXP        (VAUXP),
        .VAUXN        (VAUXN),
        .digit        (digit)
    );

    // 100 MHz clock
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    // Edge counter: after the k-th rising edge cycleNum equals k
    always @(posedge S_AXI_ACLK) cycleNum <= cycleNum + 1;

    // Hard stop in case something stalls beyond every bounded wait
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Register-map view of the model
    function automatic logic [31:0] modelRead(input logic [8:0] addr);
        if (addr[8:4] != 5'd0) return 32'h0;
        case (addr[3:2])
            2'd0:    return {31'h0, modelEnable};
            2'd1:    return {8'(modelCount[3]), 8'(modelCount[2]), 8'(modelCount[1]), 8'(modelCount[0])};
            2'd2:    return modelPwmCfg;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void modelWrite(input logic [8:0] addr, input logic [31:0] data, input int commitEdge);
        if (addr[8:4] != 5'd0) return;
        if (addr[3:2] == 2'd0) begin
            if (data[1]) begin
                for (int c = 0; c < 4; c++) modelCount[c] = 0;
            end
            if (data[0] && !modelEnable) enableEdge = commitEdge;
            modelEnable = data[0];
        end else if (addr[3:2] == 2'd2) begin
            modelPwmCfg = data;
        end
    endfunction

    // Expected digit right after the current edge: the counter reads 0 on
    // the enable edge and has stepped once per cycle since then.
    function automatic logic [15:0] modelDigit();
        int phase;
        if (!modelEnable) return 16'h0;
        phase = (cycleNum - 1 - enableEdge) % 256;
        return (phase < int'(modelPwmCfg[23:16])) ? modelPwmCfg[15:0] : 16'h0;
    endfunction

    task automatic applyWrite(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit seen;
        int hold;
        seen = 1'b0;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge S_AXI_ACLK); #1;
            if (S_AXI_AWREADY) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput("awready_timeout", 32'd0, 32'd1);
            S_AXI_AWVALID = 1'b0;
            S_AXI_WVALID  = 1'b0;
            return;
        end
        modelWrite(addr, data, cycleNum);
        checkOutput("wready_pulse", 32'(S_AXI_WREADY), 32'd1);
        checkOutput("bvalid_set", 32'(S_AXI_BVALID), 32'd1);
        checkOutput("bresp", 32'(S_AXI_BRESP), 32'd0);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        hold = $urandom_range(1, 3);
        for (int i = 0; i < hold; i++) begin
            @(posedge S_AXI_ACLK); #1;
            checkOutput("awready_one_cycle", 32'(S_AXI_AWREADY), 32'd0);
            checkOutput("wready_one_cycle", 32'(S_AXI_WREADY), 32'd0);
            checkOutput("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        checkOutput("bvalid_clear", 32'(S_AXI_BVALID), 32'd0);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic applyRead(input logic [8:0] addr, input string tag, output logic [31:0] observed);
        bit seen;
        int hold;
        logic [31:0] expected;
        seen = 1'b0;
        observed = 32'h0;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge S_AXI_ACLK); #1;
            if (S_AXI_ARREADY) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput("arready_timeout", 32'd0, 32'd1);
            S_AXI_ARVALID = 1'b0;
            return;
        end
        expected = modelRead(addr);
        observed = S_AXI_RDATA;
        checkOutput("rvalid_set", 32'(S_AXI_RVALID), 32'd1);
        checkOutput(tag, S_AXI_RDATA, expected);
        checkOutput("rresp", 32'(S_AXI_RRESP), 32'd0);
        S_AXI_ARVALID = 1'b0;
        hold = $urandom_range(1, 3);
        for (int i = 0; i < hold; i++) begin
            @(posedge S_AXI_ACLK); #1;
            checkOutput("arready_one_cycle", 32'(S_AXI_ARREADY), 32'd0);
            checkOutput("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
            checkOutput("rdata_hold", S_AXI_RDATA, expected);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        checkOutput("rvalid_clear", 32'(S_AXI_RVALID), 32'd0);
        S_AXI_RREADY = 1'b0;
    endtask

    // Drive one differential value and hold it for holdCycles edges; the model
    // counts every 0->1 step of P & ~N on an enabled channel.
    task automatic driveSpike(input logic [3:0] p, input logic [3:0] n, input int holdCycles);
        logic [3:0] lvl;
        lvl = p & ~n;
        @(posedge S_AXI_ACLK); #1;
        VAUXP = p;
        VAUXN = n;
        if (modelEnable) begin
            for (int c = 0; c < 4; c++) begin
                if (lvl[c] && !drvLevel[c]) modelCount[c] = (modelCount[c] + 1) % 256;
            end
        end
        drvLevel = lvl;
        repeat (holdCycles - 1) @(posedge S_AXI_ACLK);
    endtask

    // Random spike traffic, then a settle period so no edge is still in the
    // synchroniser when the next register access happens.
    task automatic applyStimulus(input int steps, input logic [3:0] chMask, input bit useN);
        logic [3:0] p;
        logic [3:0] n;
        for (int s = 0; s < steps; s++) begin
            p = 4'($urandom) & chMask;
            n = useN ? 4'($urandom) : 4'h0;
            driveSpike(p, n, $urandom_range(2, 4));
        end
        repeat (6) @(posedge S_AXI_ACLK);
    endtask

    task automatic checkPwm(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge S_AXI_ACLK); #1;
            checkOutput("digit", 32'(digit), 32'(modelDigit()));
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [8:0]  addr;

        // Reset
        repeat (4) @(posedge S_AXI_ACLK);
        #1;
        S_AXI_ARESET = 1'b0;
        @(posedge S_AXI_ACLK); #1;
        checkOutput("reset_awready", 32'(S_AXI_AWREADY), 32'd0);
        checkOutput("reset_wready", 32'(S_AXI_WREADY), 32'd0);
        checkOutput("reset_bvalid", 32'(S_AXI_BVALID), 32'd0);
        checkOutput("reset_arready", 32'(S_AXI_ARREADY), 32'd0);
        checkOutput("reset_rvalid", 32'(S_AXI_RVALID), 32'd0);
        checkOutput("reset_rdata", S_AXI_RDATA, 32'd0);
        checkOutput("reset_digit", 32'(digit), 32'd0);

        // CTRL write with no strobes is still a full write
        applyWrite(9'h000, 32'hDEADBEEF, 4'h0);
        applyRead(9'h000, "ctrl_read", rd);
        checkOutput("ctrl_value", rd, 32'h00000001);

        // PWMCFG full readback and one full PWM period
        applyWrite(9'h008, 32'hDEADBEEF, 4'hF);
        applyRead(9'h008, "pwmcfg_read", rd);
        checkOutput("pwmcfg_value", rd, 32'hDEADBEEF);
        checkPwm(300);

        // Read-only and unmapped locations
        applyWrite(9'h004, 32'hDEADBEEF, 4'hF);
        applyRead(9'h004, "spikes_ro", rd);
        checkOutput("spikes_zero", rd, 32'h0);
        applyRead(9'h00C, "reserved_read", rd);
        applyRead(9'h100, "unmapped_read", rd);
        checkOutput("unmapped_zero", rd, 32'h0);

        // Five clean spikes on channel 2
        for (int k = 0; k < 5; k++) begin
            driveSpike(4'b0100, 4'b0000, 3);
            driveSpike(4'b0000, 4'b0000, 3);
        end
        repeat (6) @(posedge S_AXI_ACLK);
        applyRead(9'h004, "five_spikes", rd);
        checkOutput("five_spikes_value", rd, 32'h00050000);

        // Negative leg held high masks the same toggles
        for (int k = 0; k < 5; k++) begin
            driveSpike(4'b0100, 4'b0100, 3);
            driveSpike(4'b0000, 4'b0100, 3);
        end
        driveSpike(4'b0000, 4'b0000, 3);
        repeat (6) @(posedge S_AXI_ACLK);
        applyRead(9'h004, "n_leg_masked", rd);
        checkOutput("n_leg_value", rd, 32'h00050000);

        // 260 spikes on channel 0 wrap the 8-bit counter
        for (int k = 0; k < 260; k++) begin
            driveSpike(4'b0001, 4'b0000, 2);
            driveSpike(4'b0000, 4'b0000, 2);
        end
        repeat (6) @(posedge S_AXI_ACLK);
        applyRead(9'h004, "wrap_spikes", rd);
        checkOutput("wrap_value", rd, 32'h00050004);
        applyWrite(9'h000, 32'h00000003, 4'hF);
        applyRead(9'h004, "after_clear", rd);
        checkOutput("clear_value", rd, 32'h0);
        applyRead(9'h000, "ctrl_clear_reads0", rd);
        checkOutput("ctrl_clear_value", rd, 32'h00000001);

        // Duty boundaries and the enable gate
        applyWrite(9'h008, 32'h0000FFFF, 4'hF);
        checkPwm(260);
        applyWrite(9'h008, 32'h00FFA5A5, 4'hF);
        checkPwm(260);
        applyWrite(9'h000, 32'h00000000, 4'hF);
        checkPwm(30);
        applyWrite(9'h000, 32'h00000001, 4'hF);
        checkPwm(40);

        // Randomised mix of accesses, spike traffic and PWM observation
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    addr = 9'($urandom);
                    if ($urandom_range(0, 3) != 0) addr[8:4] = 5'd0;
                    applyWrite(addr, $urandom, 4'($urandom));
                end
                1: begin
                    addr = 9'($urandom);
                    if ($urandom_range(0, 3) != 0) addr[8:4] = 5'd0;
                    applyRead(addr, "random_read", rd);
                end
                2: applyStimulus(20, 4'hF, 1'b1);
                default: checkPwm(50);
            endcase
        end

        // Long spike runs between spaced SPIKES reads
        applyWrite(9'h000, 32'h00000001, 4'hF);
        for (int r = 0; r < 4; r++) begin
            applyStimulus(3300, 4'hF, 1'b1);
            applyRead(9'h004, "long_run_read", rd);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
